// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, FSM state type and the parity helper for the
// mem_responder slice. The parity helper is also used by the bench model.
package mem_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_IDLE  = 1'b1
  } mem_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: storage for mem_responder. One synchronous write port and one
// registered read port sharing a single address.
//   clk    - clock, all activity on posedge
//   rst_n  - asynchronous active-low reset, clears only the read register
//   we     - write enable, stores wdata at addr
//   re     - read enable, loads rdata from addr
//   addr   - shared access address
//   wdata  - write word (WIDTH bits, includes parity bit when built with it)
//   rdata  - registered read word
module mem_array #(
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Contents are never reset; the responder's clear sequence initialises them.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: synthesizable responder for the single-cycle read/write
// strobe memory protocol (32 x 8 by default). After reset a clear sequence
// writes CLR_VAL to every word while busy is high; afterwards read/write
// strobes are serviced, with sticky detection of simultaneous strobes.
// Optional feature macro: MEM_PARITY_EN (per-word even parity, error injection
// on write, one-clock parity_err pulse on a mismatching read).
//   clk           - clock, all state changes on posedge
//   rst_n         - asynchronous active-low reset
//   read, write   - access strobes, sampled at posedge
//   addr          - access address
//   data_in       - write data
//   data_out      - registered read data
//   busy          - high while the clear sequence runs (accesses ignored)
//   err_collision - sticky, set when read and write are both high in idle
//   parity_err    - (MEM_PARITY_EN) pulses with data_out on parity mismatch
//   inject_err    - (MEM_PARITY_EN) inverts the stored parity bit on a write
module mem_responder #(
  parameter int                ADDR_W  = 5,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              err_collision
`ifdef MEM_PARITY_EN
  ,
  output logic              parity_err,
  input  logic              inject_err
`endif
);

  import mem_pkg::*;

`ifdef MEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  mem_state_e        state, state_nx;
  logic [ADDR_W-1:0] ptr, ptr_nx;
  logic              clearing;
  logic              coll;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [MW-1:0]     arr_wdata, arr_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MEM_CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    clearing  = 1'b0;
    coll      = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_addr  = addr;
    arr_wdata = '0;
    case (state)
      MEM_CLEAR: begin
        clearing = 1'b1;
        arr_we   = 1'b1;
        arr_addr = ptr;
        ptr_nx   = ptr + 1'b1;
        if (ptr == {ADDR_W{1'b1}}) state_nx = MEM_IDLE;
`ifdef MEM_PARITY_EN
        arr_wdata = {parity(CLR_VAL), CLR_VAL};
`else
        arr_wdata = CLR_VAL;
`endif
      end
      MEM_IDLE: begin
        // Simultaneous strobes perform no access at all.
        coll   = read & write;
        arr_we = write & ~read;
        arr_re = read & ~write;
`ifdef MEM_PARITY_EN
        arr_wdata = {parity(data_in) ^ inject_err, data_in};
`else
        arr_wdata = data_in;
`endif
      end
      default: state_nx = MEM_CLEAR;
    endcase
  end

  assign busy = clearing;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    err_collision <= 1'b0;
    else if (coll) err_collision <= 1'b1;
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (MW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign data_out = arr_rdata[DATA_W-1:0];

`ifdef MEM_PARITY_EN
  logic vld_p1;

  // ---- stage p1: registered read word available ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= arr_re;
  end

  // Qualified by the read-valid flag so the pulse lasts exactly the cycle
  // in which the freshly read word is presented.
  assign parity_err = vld_p1 &
                      (parity(arr_rdata[DATA_W-1:0]) != arr_rdata[DATA_W]);
`endif

endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous 32 x 8 memory that answers the single-cycle read/write strobe protocol driven by the memory test bench. It is the responder end of that interface. It owns storage, a post-reset clear sequencer, registered read data and collision detection. It sits under the lab top level in place of the behavioural memory model, so benches exercise a synthesizable responder.

## Interface
Parameters:
- ADDR_W, 5, address width; depth is 2**ADDR_W (32).
- DATA_W, 8, data width.
- CLR_VAL, 8'h00, value written to every location by the clear sequence.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- read  input  1  read strobe, sampled at posedge.
- write  input  1  write strobe, sampled at posedge.
- addr  input  ADDR_W  access address.
- data_in  input  DATA_W  write data.
- data_out  output  DATA_W  registered read data.
- busy  output  1  high while the clear sequence runs; accesses are ignored.
- err_collision  output  1  sticky flag: read and write were both seen high.
- parity_err  output  1  present only with MEM_PARITY_EN.
- inject_err  input  1  present only with MEM_PARITY_EN.

## Operation
- State machine has two states, MEM_CLEAR and MEM_IDLE.
- Reset (rst_n low, any time, including mid-clear or mid-access):
  - state = MEM_CLEAR, clear pointer = 0, busy = 1, data_out = 0, err_collision = 0, parity_err = 0.
  - Memory contents are not reset directly.
- MEM_CLEAR:
  - Each posedge writes CLR_VAL to mem[ptr], then ptr++.
  - After writing address 31, the next state is MEM_IDLE and busy drops.
  - read and write are ignored and data_out holds 0.
  - Collisions are not flagged during MEM_CLEAR.
- MEM_IDLE access rules at each posedge:
  - write=1, read=0: mem[addr] <= data_in. data_out unchanged.
  - read=1, write=0: data_out <= mem[addr].
  - read=1, write=1: no write, data_out unchanged, err_collision <= 1. The flag stays set until reset.
  - Both low: no change.
- Addresses wrap naturally at ADDR_W bits. There is no out-of-range case.
- A read of an address written in an earlier cycle returns the new data. Same-cycle read/write is impossible because it is a collision.

## Timing
- Clear takes exactly 32 clocks after rst_n deasserts. busy is low from the 33rd posedge onward.
- Write latency: data is stored at the posedge where the strobe is sampled.
- Read latency: 1 clock. The bench raises read at a negedge and samples data_out at the following negedge; that is valid.
- err_collision asserts at the posedge of the collision.
- Strobes do not have to be pulses. A strobe held high repeats the access every cycle.

## Configuration
- Macro MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed at write time.
  - If inject_err=1 during a write, the stored parity bit is inverted.
  - On a read, parity is recomputed over the stored data.
  - On a mismatch, parity_err pulses high for one clock, aligned with the updated data_out.
  - The clear sequence writes correct parity.
- Undefined:
  - The parity_err and inject_err ports do not exist.
  - The array is DATA_W bits wide and no parity logic is built.

## Structure
- Package mem_pkg:
  - ADDR_W, DATA_W and MEM_DEPTH constants.
  - mem_state_e enum {MEM_CLEAR, MEM_IDLE}.
  - A parity function used by both the RTL and the bench.
- Sub-module mem_array: storage only, with one write port and one registered read port. Its width is DATA_W, plus 1 when MEM_PARITY_EN is defined.
- mem_responder holds the FSM, clear pointer, strobe decode and error flags.

## Test plan
- Reset release:
  - busy stays 1 for 32 clocks, then 0.
  - Reading all 32 addresses returns 8'h00.
  - data_out = 0 throughout the clear.
- Data = address:
  - Write i to address i for i = 0..31, then read back.
  - Every read returns i one clock after the strobe.
- Collision:
  - In MEM_IDLE, raise read and write together with addr=5 and data_in=8'hAA.
  - err_collision rises and stays 1. mem[5] is unchanged. data_out is unchanged.
- Reset mid-clear:
  - Pulse rst_n low 10 clocks into the clear.
  - busy then lasts a full 32 clocks from the new release, and all locations read 8'h00.
- Back-to-back:
  - Write 8'h3C to address 31, then read address 31 on the next clock.
  - The read returns 8'h3C. Reading address 0 returns its own value.
- MEM_PARITY_EN:
  - Write 8'h55 to address 7 with inject_err=1, then read address 7.
  - data_out = 8'h55 with a one-clock parity_err pulse.
  - The same sequence with inject_err=0 gives no pulse.
